ref_clk_training_ctrl: RTL and testbench

//  Multi-lane delay-line training controller for DDR4 reference-clock IOD lanes.

---
 rtl/ref_clk_training_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_ref_clk_training_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ref_clk_training_ctrl.sv
// Multi-lane IOD delay-line training controller: per-lane sweep to the first RX change, then back off.
// Optional eye-monitor edge criterion is compiled in with `define REF_CLK_TRAIN_EYE_MON_EN.

module ref_clk_training_lane (
  input  logic sel,
  input  logic load_req,
  input  logic move_req,
  input  logic dir_req,
  input  logic clr_req,
  output logic load,
  output logic move,
  output logic dir,
  output logic clr
);
  assign load = sel & load_req;
  assign move = sel & move_req;
  assign dir  = sel & dir_req;
  assign clr  = sel & clr_req;
endmodule

module ref_clk_training_ctrl #(
  parameter int NUM_LANES     = 4,
  parameter int RX_W          = 8,
  parameter int TAP_W         = 8,
  parameter int MAX_TAPS      = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 4,
  parameter int BACKOFF       = 16
) (
  input  logic                       FAB_CLK,
  input  logic                       ARST_N,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_LANES-1:0]       fail,
  output logic [TAP_W*NUM_LANES-1:0] edge_tap,
  input  logic [RX_W*NUM_LANES-1:0]  rx_data,
  output logic [NUM_LANES-1:0]       delay_line_load,
  output logic [NUM_LANES-1:0]       delay_line_move,
  output logic [NUM_LANES-1:0]       delay_line_direction,
  input  logic [NUM_LANES-1:0]       delay_line_out_of_range,
  input  logic [NUM_LANES-1:0]       eye_monitor_early,
  input  logic [NUM_LANES-1:0]       eye_monitor_late,
  output logic [NUM_LANES-1:0]       eye_monitor_clear_flags
);
  localparam int LW   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CMAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [TAP_W-1:0] MAX_T       = TAP_W'(MAX_TAPS);
  localparam logic [TAP_W-1:0] BACK_T      = TAP_W'(BACKOFF);
  localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]    SAMPLE_LAST = CW'(SAMPLES - 1);
  localparam logic [LW-1:0]    LAST_LANE   = LW'(NUM_LANES - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD    = 4'd1;
  localparam logic [3:0] S_SETTLE  = 4'd2;
  localparam logic [3:0] S_SAMPLE  = 4'd3;
  localparam logic [3:0] S_MOVE    = 4'd4;
  localparam logic [3:0] S_BACK    = 4'd5;
  localparam logic [3:0] S_BSETTLE = 4'd6;
  localparam logic [3:0] S_NEXT    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]       state;
  logic [LW-1:0]    lane;
  logic [TAP_W-1:0] tap, back_left;
  logic [CW-1:0]    cnt;
  logic             hit;
  logic [RX_W-1:0]  ref_word;

  logic [NUM_LANES-1:0][RX_W-1:0]  rx_w;
  logic [NUM_LANES-1:0][TAP_W-1:0] edge_q;
  assign rx_w     = rx_data;
  assign edge_tap = edge_q;

  logic [RX_W-1:0] word;
  logic            oor, eye_hit, mis;
  logic            load_req, move_req, dir_req, clr_req;

  assign word = rx_w[lane];
  assign oor  = delay_line_out_of_range[lane];

`ifdef REF_CLK_TRAIN_EYE_MON_EN
  assign eye_hit = eye_monitor_early[lane] | eye_monitor_late[lane];
  // Flags are cleared at the first SETTLE cycle so they only reflect the current tap.
  assign clr_req = (state == S_SETTLE) && (cnt == '0);
`else
  logic unused_eye;
  assign unused_eye = ^{eye_monitor_early, eye_monitor_late};
  assign eye_hit    = 1'b0;
  assign clr_req    = 1'b0;
`endif

  // Tap 0 only establishes the reference; edges count from tap 1 upward.
  assign mis      = (tap != '0) && ((word != ref_word) || eye_hit);
  assign load_req = (state == S_LOAD);
  assign dir_req  = (state == S_MOVE) && (tap != MAX_T);
  assign move_req = dir_req || ((state == S_BACK) && (back_left != '0));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ref_clk_training_lane u_lane (
      .sel      (lane == LW'(i)),
      .load_req (load_req),
      .move_req (move_req),
      .dir_req  (dir_req),
      .clr_req  (clr_req),
      .load     (delay_line_load[i]),
      .move     (delay_line_move[i]),
      .dir      (delay_line_direction[i]),
      .clr      (eye_monitor_clear_flags[i])
    );
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state     <= S_IDLE;
      lane      <= '0;
      tap       <= '0;
      back_left <= '0;
      cnt       <= '0;
      hit       <= 1'b0;
      ref_word  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= '0;
      edge_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          lane   <= '0;
          busy   <= 1'b1;
          done   <= 1'b0;
          fail   <= '0;
          edge_q <= '0;
          state  <= S_LOAD;
        end
        S_LOAD: begin
          tap   <= '0;
          cnt   <= '0;
          hit   <= 1'b0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (oor) begin
            fail[lane]   <= 1'b1;
            edge_q[lane] <= tap;
            state        <= S_NEXT;
          end else if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            hit   <= 1'b0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (oor) begin
            fail[lane]   <= 1'b1;
            edge_q[lane] <= tap;
            state        <= S_NEXT;
          end else begin
            if ((tap == '0) && (cnt == '0)) ref_word <= word;
            if (cnt == SAMPLE_LAST) begin
              cnt <= '0;
              if (hit || mis) begin
                back_left <= (tap < BACK_T) ? tap : BACK_T;
                state     <= S_BACK;
              end else begin
                state <= S_MOVE;
              end
            end else begin
              cnt <= cnt + 1'b1;
              hit <= hit | mis;
            end
          end
        end
        S_MOVE: begin
          if (tap == MAX_T) begin
            fail[lane]   <= 1'b1;
            edge_q[lane] <= tap;
            state        <= S_NEXT;
          end else begin
            tap   <= tap + 1'b1;
            cnt   <= '0;
            state <= S_SETTLE;
          end
        end
        S_BACK: begin
          if (back_left == '0) begin
            edge_q[lane] <= tap;
            state        <= S_NEXT;
          end else begin
            back_left <= back_left - 1'b1;
            tap       <= tap - 1'b1;
            cnt       <= '0;
            state     <= S_BSETTLE;
          end
        end
        S_BSETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_BACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (lane == LAST_LANE) begin
            state <= S_DONE;
          end else begin
            lane  <= lane + 1'b1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ref_clk_training_ctrl.sv
// Bench for ref_clk_training_ctrl: behavioural IOD lane model plus a per-run scoreboard of lane results.
module tb_ref_clk_training_ctrl;
  localparam int NL = 4, RX_W = 8, TAP_W = 8, MAX_TAPS = 127, BACKOFF = 16;
  localparam int BOUND = 20000;

  logic                   FAB_CLK = 1'b0;
  logic                   ARST_N  = 1'b0;
  logic                   start   = 1'b0;
  logic                   busy, done;
  logic [NL-1:0]          fail;
  logic [TAP_W*NL-1:0]    edge_tap;
  logic [RX_W*NL-1:0]     rx_data = '0;
  logic [NL-1:0]          delay_line_load, delay_line_move, delay_line_direction;
  logic [NL-1:0]          delay_line_out_of_range = '0;
  logic [NL-1:0]          eye_monitor_early = '0, eye_monitor_late = '0;
  logic [NL-1:0]          eye_monitor_clear_flags;

  ref_clk_training_ctrl dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .start                   (start),
    .busy                    (busy),
    .done                    (done),
    .fail                    (fail),
    .edge_tap                (edge_tap),
    .rx_data                 (rx_data),
    .delay_line_load         (delay_line_load),
    .delay_line_move         (delay_line_move),
    .delay_line_direction    (delay_line_direction),
    .delay_line_out_of_range (delay_line_out_of_range),
    .eye_monitor_early       (eye_monitor_early),
    .eye_monitor_late        (eye_monitor_late),
    .eye_monitor_clear_flags (eye_monitor_clear_flags)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    int tap;
    int fl;
    int inc;
    int dec;
    int loads;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int mtap[NL], edge_at[NL], oor_at[NL], late_at[NL];
  int inc_n[NL], dec_n[NL], load_n[NL];
  int clr_n = 0, viol = 0, exp_load_lane = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // IOD lane model: tracks tap from pulses and drives RX/range/eye flags from it.
  initial begin
    forever begin
      @(negedge FAB_CLK);
      if ($countones(delay_line_load | delay_line_move) > 1 || |(delay_line_load & delay_line_move))
        viol++;
      clr_n += $countones(eye_monitor_clear_flags);
      for (int i = 0; i < NL; i++) begin
        if (delay_line_load[i]) begin
          load_n[i]++;
          mtap[i] = 0;
          chk($sformatf("load_order_l%0d", i), i, exp_load_lane);
          exp_load_lane++;
        end
        if (delay_line_move[i]) begin
          if (delay_line_direction[i]) begin inc_n[i]++; mtap[i]++; end
          else begin dec_n[i]++; mtap[i]--; end
        end
        rx_data[i*RX_W +: RX_W]    = (edge_at[i] != 0 && mtap[i] >= edge_at[i]) ? 8'h3C : 8'hA5;
        delay_line_out_of_range[i] = (oor_at[i] >= 0 && mtap[i] >= oor_at[i]);
        eye_monitor_late[i]        = (late_at[i] >= 0 && mtap[i] >= late_at[i]);
      end
    end
  end

  function automatic exp_t exp_lane(int i);
    exp_t e;
    int eff;
    eff = edge_at[i];
`ifdef REF_CLK_TRAIN_EYE_MON_EN
    if (late_at[i] > 0 && (eff == 0 || late_at[i] < eff)) eff = late_at[i];
`endif
    e.loads = 1;
    if (oor_at[i] >= 0 && (eff == 0 || oor_at[i] <= eff)) begin
      e.fl = 1; e.tap = oor_at[i]; e.inc = oor_at[i]; e.dec = 0;
    end else if (eff == 0) begin
      e.fl = 1; e.tap = MAX_TAPS; e.inc = MAX_TAPS; e.dec = 0;
    end else begin
      e.fl = 0; e.dec = (eff < BACKOFF) ? eff : BACKOFF;
      e.tap = eff - e.dec; e.inc = eff;
    end
    return e;
  endfunction

  task automatic setup(input int e0, input int e1, input int e2, input int e3, input int oor0,
                       input int late_all);
    edge_at = '{e0, e1, e2, e3};
    oor_at  = '{oor0, -1, -1, -1};
    late_at = '{late_all, late_all, late_all, late_all};
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NL; i++) begin inc_n[i] = 0; dec_n[i] = 0; load_n[i] = 0; end
    exp_load_lane = 0;
  endtask

  task automatic run(input string name, input bit poke);
    int n;
    exp_t e;
    for (int i = 0; i < NL; i++) sb.push_back(exp_lane(i));
    clear_counts();
    @(negedge FAB_CLK) start = 1'b1;
    @(negedge FAB_CLK) start = 1'b0;
    chk({name, "_busy_up"}, busy, 1);
    chk({name, "_done_clr"}, done, 0);
    if (poke) begin
      for (int k = 0; k < 3; k++) begin
        repeat (300) @(negedge FAB_CLK);
        start = 1'b1;
        @(negedge FAB_CLK) start = 1'b0;
      end
    end
    n = 0;
    while (!done && n < BOUND) begin @(negedge FAB_CLK); n++; end
    chk({name, "_in_time"}, (n < BOUND), 1);
    chk({name, "_busy_dn"}, busy, 0);
    for (int i = 0; i < NL; i++) begin
      e = sb.pop_front();
      chk($sformatf("%s_l%0d_tap", name, i), edge_tap[i*TAP_W +: TAP_W], e.tap);
      chk($sformatf("%s_l%0d_fail", name, i), fail[i], e.fl);
      chk($sformatf("%s_l%0d_inc", name, i), inc_n[i], e.inc);
      chk($sformatf("%s_l%0d_dec", name, i), dec_n[i], e.dec);
      chk($sformatf("%s_l%0d_load", name, i), load_n[i], e.loads);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_fail"}, fail, 0);
    chk({name, "_edge"}, edge_tap, 0);
    chk({name, "_pulses"}, {delay_line_load, delay_line_move, delay_line_direction,
                            eye_monitor_clear_flags}, 0);
  endtask

  initial begin
    int n, frozen;
    for (int i = 0; i < NL; i++) mtap[i] = 0;
    setup(40, 40, 40, 40, -1, -1);
    clear_counts();
    #2 chk_all_zero("reset");
    @(negedge FAB_CLK) ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    clr_n = 0;

    setup(40, 40, 40, 40, -1, -1); run("base", 1'b0);
    setup(40, 10, 40, 40, -1, -1); run("short", 1'b0);
    setup(40, 40, 0, 40, -1, -1);  run("never", 1'b0);
    setup(40, 40, 40, 40, 5, -1);  run("oor", 1'b0);
    setup(40, 40, 40, 40, -1, -1); run("ignore_start", 1'b1);

    // Abort mid-sweep of lane 1 with reset, then retrain from scratch.
    clear_counts();
    @(negedge FAB_CLK) start = 1'b1;
    @(negedge FAB_CLK) start = 1'b0;
    n = 0;
    while (!(load_n[1] == 1 && mtap[1] == 20) && n < BOUND) begin @(negedge FAB_CLK); n++; end
    chk("abort_reach", (n < BOUND), 1);
    #2 ARST_N = 1'b0;
    #1 chk_all_zero("abort");
    frozen = inc_n[1] + dec_n[1];
    repeat (5) @(negedge FAB_CLK);
    chk("abort_nomove", inc_n[1] + dec_n[1], frozen);
    chk_all_zero("abort_hold");
    ARST_N = 1'b1;
    @(negedge FAB_CLK);
    run("retrain", 1'b0);

`ifdef REF_CLK_TRAIN_EYE_MON_EN
    clr_n = 0;
    setup(0, 0, 0, 0, -1, 30); run("eye", 1'b0);
    chk("eye_clr_cnt", clr_n, NL * 31);
`else
    chk("clr_never", clr_n, 0);
`endif
    chk("pulse_excl", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
